i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 105 ++++++++++
 tb/tb_i2s_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S transmitter: pulls words from a first-word-fall-through buffer and
// serialises them MSB first, left slot then right, with the standard one-bit delay.
module i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  rd_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  underrun_o
);

    localparam int SLOTS = 2 * DATA_WIDTH;
    localparam int SW    = $clog2(SLOTS);
    localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_RIGHT = SW'(DATA_WIDTH);

    logic [DW-1:0]         div_q,   div_d;
    logic                  bclk_q,  bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic [SW-1:0]         slot_q,  slot_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;

    logic          half_tick;
    logic          fall;
    logic          load;
    logic [SW-1:0] slot_inc;

    always_comb begin
        half_tick = en_i && (div_q == DIV_LAST);
        fall      = half_tick && bclk_q;
        slot_inc  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        load      = fall && ((slot_inc == '0) || (slot_inc == SLOT_RIGHT));
    end

    // The pop strobe and underrun flag mark the cycle that closes on a load edge.
    assign rd_o       = load && !empty_i;
    assign underrun_o = load && empty_i;

    always_comb begin
        div_d   = div_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        slot_d  = slot_q;
        shift_d = shift_q;
        if (!en_i) begin
            div_d   = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            slot_d  = SLOT_LAST;
            shift_d = '0;
        end else begin
            div_d = half_tick ? '0 : div_q + 1'b1;
            if (half_tick) begin
                bclk_d = ~bclk_q;
            end
            if (fall) begin
                slot_d = slot_inc;
                // Equals the counter MSB for power-of-two widths, and stays correct otherwise.
                lrclk_d = (slot_inc >= SLOT_RIGHT);
                sdata_d = shift_q[DATA_WIDTH-1];
                if (load) begin
                    shift_d = empty_i ? '0 : rdata_i;
                end else begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            slot_q  <= SLOT_LAST;
            shift_q <= '0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = lrclk_q;
    assign sdata_o = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx; expectations come from frame arithmetic
// (edge counts since enable) plus a queue model of the upstream buffer.
module tb_i2s_tx;

    localparam int W  = 16;
    localparam int CD = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         en_i;
    logic         empty_i;
    logic [W-1:0] rdata_i;
    logic         rd_o, bclk_o, lrclk_o, sdata_o, underrun_o;

    i2s_tx #(.DATA_WIDTH(W), .CLK_DIV(CD)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .empty_i    (empty_i),
        .rdata_i    (rdata_i),
        .rd_o       (rd_o),
        .bclk_o     (bclk_o),
        .lrclk_o    (lrclk_o),
        .sdata_o    (sdata_o),
        .underrun_o (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] fifo_q[$];   // upstream buffer contents
    logic [W-1:0] sent_q[$];   // words loaded into the transmitter, in order (0 on underrun)
    int           m;           // clk edges sampled with en_i high since enable
    int           rd_cnt;
    int           ur_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t m=%0d)", tag, obs, exp, $time, m);
        end
    endtask

    task automatic refresh();
        empty_i = (fifo_q.size() == 0);
        rdata_i = empty_i ? W'($urandom) : fifo_q[0];
    endtask

    task automatic model_clear();
        m = 0;
        sent_q.delete();
    endtask

    // One clock cycle: check at the falling clk edge, advance the model after the rising edge.
    task automatic tick();
        int           f, idx, pos, k;
        logic         lr_e, sd_e, load_n, rd_e, ur_e;
        logic [W-1:0] word;
        @(negedge clk_i);
        f    = m / (2 * CD);
        lr_e = 1'b0;
        sd_e = 1'b0;
        if (f >= 1) lr_e = (((f - 1) / W) % 2) == 1;
        if (f >= 2) begin
            idx = (f - 2) / W;
            pos = (f - 2) % W;
            if (idx < sent_q.size()) begin
                word = sent_q[idx];
                sd_e = word[W-1-pos];
            end
        end
        load_n = 1'b0;
        if (((m + 1) % (2 * CD)) == 0) begin
            k      = (m + 1) / (2 * CD) - 1;
            load_n = (k % W) == 0;
        end
        rd_e = rst_ni && en_i && load_n && (fifo_q.size() != 0);
        ur_e = rst_ni && en_i && load_n && (fifo_q.size() == 0);
        check("bclk",     32'(bclk_o),     32'(rst_ni && ((m / CD) % 2 == 1)));
        check("lrclk",    32'(lrclk_o),    32'(rst_ni && lr_e));
        check("sdata",    32'(sdata_o),    32'(rst_ni && sd_e));
        check("rd",       32'(rd_o),       32'(rd_e));
        check("underrun", 32'(underrun_o), 32'(ur_e));
        if (rd_o === 1'b1) rd_cnt++;
        if (underrun_o === 1'b1) ur_cnt++;
        @(posedge clk_i);
        #1;
        if (rst_ni && en_i) begin
            if (rd_e) begin
                $display("load %s word %04h", (sent_q.size() % 2 == 0) ? "L" : "R", fifo_q[0]);
                sent_q.push_back(fifo_q.pop_front());
            end
            if (ur_e) begin
                $display("load %s word underrun", (sent_q.size() % 2 == 0) ? "L" : "R");
                sent_q.push_back('0);
            end
            m++;
        end else begin
            model_clear();
        end
        refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_ni = 1'b0;
        en_i   = 1'b0;
        model_clear();
        rd_cnt = 0;
        ur_cnt = 0;
        refresh();
        run(3);
        rst_ni = 1'b1;
        run(4);

        // Single frame of two preloaded words.
        fifo_q.push_back(16'hABCD);
        fifo_q.push_back(16'h1234);
        refresh();
        rd_cnt = 0;
        en_i   = 1'b1;
        run(260);
        check("frame_rd_count", 32'(rd_cnt), 32'd2);
        check("frame_word_l", 32'(sent_q[0]), 32'hABCD);
        en_i = 1'b0;
        run(3);

        // Underrun with an empty buffer: one pulse per slot (64 clk).
        ur_cnt = 0;
        rd_cnt = 0;
        en_i   = 1'b1;
        run(200);
        check("ur_count", 32'(ur_cnt), 32'd4);
        check("ur_rd_count", 32'(rd_cnt), 32'd0);
        en_i = 1'b0;
        run(3);

        // Streaming 0..7 then underruns.
        for (int i = 0; i < 8; i++) fifo_q.push_back(W'(i));
        refresh();
        rd_cnt = 0;
        ur_cnt = 0;
        en_i   = 1'b1;
        run(600);
        check("stream_rd_count", 32'(rd_cnt), 32'd8);
        check("stream_ur_count", 32'(ur_cnt), 32'd2);
        en_i = 1'b0;
        run(3);

        // Disable at slot 20, then re-enable with fresh words.
        for (int i = 0; i < 6; i++) fifo_q.push_back(W'($urandom));
        refresh();
        en_i = 1'b1;
        for (int i = 0; i < 400 && m < 84; i++) tick();
        check("reach_slot20", 32'(m), 32'd84);
        en_i = 1'b0;
        rd_cnt = 0;
        run(10);
        check("disabled_rd_count", 32'(rd_cnt), 32'd0);
        en_i = 1'b1;
        run(200);
        en_i = 1'b0;
        run(3);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 4; i++) fifo_q.push_back(W'($urandom));
        refresh();
        en_i = 1'b1;
        run(100);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_bclk",  32'(bclk_o),     32'd0);
        check("arst_lrclk", 32'(lrclk_o),    32'd0);
        check("arst_sdata", 32'(sdata_o),    32'd0);
        check("arst_rd",    32'(rd_o),       32'd0);
        check("arst_ur",    32'(underrun_o), 32'd0);
        en_i = 1'b0;
        fifo_q.delete();
        model_clear();
        refresh();
        run(3);
        rst_ni = 1'b1;
        run(6);

        // Random sessions with pushes arriving while transmitting.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(50, 700);
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) fifo_q.push_back(W'($urandom));
            refresh();
            en_i = 1'b1;
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 40) == 0) begin
                    fifo_q.push_back(W'($urandom));
                    refresh();
                end
                tick();
            end
            en_i = 1'b0;
            run($urandom_range(1, 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
